// File: rtl/sseg_pkg.sv
// Shared types and constants for the 7-segment scan decoder: FSM state codes,
// glyph decode result and the active-high {g..a} glyph table for hex digits 0..F.
package sseg_pkg;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSettle  = 2'd1;
    localparam logic [1:0] StSampled = 2'd2;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] hex;
    } glyph_t;

    localparam logic [6:0] GlyphTable [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/sseg_scan_decoder_if.sv
// Display-side bundle for sseg_scan_decoder: segs/an from the driver, decoded frame back.
// The dp field and its modport entries exist only with SSEG_DP_CAPTURE_EN defined.
interface sseg_scan_decoder_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [7:0]              segs;
    logic [NUM_DIGITS-1:0]   an;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    frame_valid;
    logic                    value_chg;
    logic                    err;
`ifdef SSEG_DP_CAPTURE_EN
    logic [NUM_DIGITS-1:0]   dp;

    modport master (output segs, an, input value, blank, frame_valid, value_chg, err, dp);
    modport slave  (input segs, an, output value, blank, frame_valid, value_chg, err, dp);
`else
    modport master (output segs, an, input value, blank, frame_valid, value_chg, err);
    modport slave  (input segs, an, output value, blank, frame_valid, value_chg, err);
`endif
endinterface

// File: rtl/sseg_glyph_decode.sv
// Combinational glyph decoder: active-low segs[6:0] to {legal, blank, hex}.
// A dark digit is legal and blank and reads as hex 0.
module sseg_glyph_decode
    import sseg_pkg::*;
(
    input  logic [6:0] segs_n_i,
    output glyph_t     glyph_o
);

    logic [6:0] segs_on;
    assign segs_on = ~segs_n_i;

    always_comb begin
        glyph_o = '0;
        if (segs_on == 7'h00) begin
            glyph_o.legal = 1'b1;
            glyph_o.blank = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (segs_on == GlyphTable[i]) begin
                    glyph_o.legal = 1'b1;
                    glyph_o.hex   = 4'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Monitor for a multiplexed 7-segment display: rebuilds the shown hex frame, flags bad glyphs.
// Optional macro SSEG_DP_CAPTURE_EN also captures the decimal points per digit.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    sseg_scan_decoder_if.slave  bus
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef SSEG_DP_CAPTURE_EN
    localparam int unsigned SegW = 8;
`else
    localparam int unsigned SegW = 7;
    logic unused_dp_in;
    assign unused_dp_in = bus.segs[7];
`endif

    logic [SegW-1:0]         segs_q, held_segs_q, held_segs_d;
    logic [NUM_DIGITS-1:0]   an_q, held_an_q, held_an_d;
    logic [1:0]              state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [TmoW-1:0]         tmo_q, tmo_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, value_q, value_d;
    logic [NUM_DIGITS-1:0]   blank_stg_q, blank_stg_d, blank_q, blank_d, seen_q, seen_d;
    logic                    fv_q, fv_d, chg_q, chg_d, err_q, err_d;

    logic            an_valid, changed, sample, legal_sample, complete, tmo_hit;
    logic [IdxW-1:0] idx;
    glyph_t          glyph;

    sseg_glyph_decode u_glyph_decode (
        .segs_n_i (segs_q[6:0]),
        .glyph_o  (glyph)
    );

    always_comb begin
        idx      = '0;
        an_valid = $onehot(~an_q);
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) idx = IdxW'(i);
        end
    end

    // Stability is judged against the copy latched when the dwell started.
    assign changed = (an_q != held_an_q) || (segs_q != held_segs_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        held_an_d   = held_an_q;
        held_segs_d = held_segs_q;
        if (!an_valid) begin
            state_d = StIdle;
        end else if (state_q == StIdle || changed) begin
            state_d     = StSettle;
            cnt_d       = CntW'(1);
            held_an_d   = an_q;
            held_segs_d = segs_q;
        end else if (state_q == StSettle) begin
            cnt_d = cnt_q + CntW'(1);
        end
        sample = (state_d == StSettle) && (cnt_d == CntW'(STABLE_CYCLES));
        if (sample) state_d = StSampled;
    end

    assign legal_sample = sample && glyph.legal;
    assign complete     = &seen_q;
    assign tmo_hit      = !legal_sample && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        shadow_d    = shadow_q;
        blank_stg_d = blank_stg_q;
        seen_d      = seen_q;
        value_d     = value_q;
        blank_d     = blank_q;
        fv_d        = fv_q;
        chg_d       = 1'b0;
        err_d       = sample && !glyph.legal;
        tmo_d       = tmo_q;
        if (legal_sample) begin
            tmo_d = '0;
        end else if (tmo_q != TmoW'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q + TmoW'(1);
        end
        if (tmo_hit) begin
            fv_d   = 1'b0;
            seen_d = '0;
        end
        // Completion overrides a coincident timeout.
        if (complete) begin
            value_d = shadow_q;
            blank_d = blank_stg_q;
            fv_d    = 1'b1;
            chg_d   = (shadow_q != value_q) || !fv_q;
            seen_d  = '0;
        end
        if (legal_sample) begin
            shadow_d[{idx, 2'b00} +: 4] = glyph.hex;
            blank_stg_d[idx]            = glyph.blank;
            seen_d[idx]                 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segs_q      <= '0;
            an_q        <= '0;
            held_segs_q <= '0;
            held_an_q   <= '0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            tmo_q       <= '0;
            shadow_q    <= '0;
            blank_stg_q <= '0;
            seen_q      <= '0;
            value_q     <= '0;
            blank_q     <= '0;
            fv_q        <= 1'b0;
            chg_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            segs_q      <= bus.segs[SegW-1:0];
            an_q        <= bus.an;
            held_segs_q <= held_segs_d;
            held_an_q   <= held_an_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            shadow_q    <= shadow_d;
            blank_stg_q <= blank_stg_d;
            seen_q      <= seen_d;
            value_q     <= value_d;
            blank_q     <= blank_d;
            fv_q        <= fv_d;
            chg_q       <= chg_d;
            err_q       <= err_d;
        end
    end

`ifdef SSEG_DP_CAPTURE_EN
    logic [NUM_DIGITS-1:0] dp_stg_q, dp_stg_d, dp_q, dp_d;

    always_comb begin
        dp_stg_d = dp_stg_q;
        dp_d     = dp_q;
        if (complete) dp_d = dp_stg_q;
        if (legal_sample) dp_stg_d[idx] = segs_q[7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_stg_q <= '0;
            dp_q     <= '0;
        end else begin
            dp_stg_q <= dp_stg_d;
            dp_q     <= dp_d;
        end
    end

    assign bus.dp = dp_q;
`endif

    assign bus.value       = value_q;
    assign bus.blank       = blank_q;
    assign bus.frame_valid = fv_q;
    assign bus.value_chg   = chg_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Scoreboard bench for sseg_scan_decoder: expected frames are queued as scans are driven
// and popped on each value_chg pulse; pulse counts are checked at the end of each step.
module tb_sseg_scan_decoder;

    localparam int unsigned Tmo = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sseg_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

    sseg_scan_decoder #(
        .NUM_DIGITS     (4),
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int chg_cnt = 0;
    int err_cnt = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.value_chg) begin
            chg_cnt++;
            if (exp_q.size() > 0) check("chg_value", {16'h0, bus.value}, {16'h0, exp_q.pop_front()});
        end
        if (rst_n && bus.err) err_cnt++;
    end

    task automatic show(input logic [3:0] an, input logic [7:0] segs, input int n);
        bus.an   = an;
        bus.segs = segs;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [7:0] d0, d1, d2, d3, input int n);
        show(4'b1110, d0, n);
        show(4'b1101, d1, n);
        show(4'b1011, d2, n);
        show(4'b0111, d3, n);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.an   = 4'b1111;
        bus.segs = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_value", {16'h0, bus.value}, 32'h0);
        check("rst_flags", {bus.blank, bus.frame_valid, bus.value_chg, bus.err}, 32'h0);
        rst_n = 1'b1;

        // 1: first frame "123F"
        exp_q.push_back(16'h123F);
        scan(8'h8E, 8'hB0, 8'hA4, 8'hF9, 8);
        settle();
        check("t1_value", {16'h0, bus.value}, 32'h123F);
        check("t1_fv", bus.frame_valid, 1);
        check("t1_chg_cnt", chg_cnt, 1);
        check("t1_blank", bus.blank, 0);

        // 2: identical frames do not pulse, then one digit changes
        scan(8'h8E, 8'hB0, 8'hA4, 8'hF9, 8);
        scan(8'h8E, 8'hB0, 8'hA4, 8'hF9, 8);
        settle();
        check("t2_no_chg", chg_cnt, 1);
        exp_q.push_back(16'h1230);
        scan(8'hC0, 8'hB0, 8'hA4, 8'hF9, 8);
        settle();
        check("t2_value", {16'h0, bus.value}, 32'h1230);
        check("t2_chg_cnt", chg_cnt, 2);

        // 3: dwell too short, then two anodes active
        scan(8'h80, 8'h80, 8'h80, 8'h80, 3);
        show(4'b1100, 8'h80, 10);
        scan(8'h80, 8'h80, 8'h80, 8'h80, 3);
        settle();
        check("t3_value", {16'h0, bus.value}, 32'h1230);
        check("t3_fv", bus.frame_valid, 1);
        check("t3_chg_cnt", chg_cnt, 2);

        // 4: illegal glyph on digit 2 blocks completion until corrected
        scan(8'hF9, 8'hB0, 8'hFE, 8'hF9, 8);
        settle();
        check("t4_err_cnt", err_cnt, 1);
        check("t4_no_chg", chg_cnt, 2);
        check("t4_held", {16'h0, bus.value}, 32'h1230);
        exp_q.push_back(16'h1231);
        show(4'b1011, 8'hA4, 8);
        settle();
        check("t4_value", {16'h0, bus.value}, 32'h1231);
        check("t4_chg_cnt", chg_cnt, 3);

        // 5: dark digit 3
        exp_q.push_back(16'h0321);
        scan(8'hF9, 8'hA4, 8'hB0, 8'hFF, 8);
        settle();
        check("t5_value", {16'h0, bus.value}, 32'h0321);
        check("t5_blank", bus.blank, 4'b1000);
        check("t5_chg_cnt", chg_cnt, 4);

        // 6: reset mid-frame discards the partial frame
        show(4'b1110, 8'h80, 8);
        rst_n = 1'b0;
        #1;
        check("t6_rst_value", {16'h0, bus.value}, 32'h0);
        check("t6_rst_flags", {bus.blank, bus.frame_valid, bus.value_chg, bus.err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        show(4'b1101, 8'hA4, 8);
        show(4'b1011, 8'hB0, 8);
        show(4'b0111, 8'hC0, 8);
        settle();
        check("t6_partial_fv", bus.frame_valid, 0);
        check("t6_partial_chg", chg_cnt, 4);
        exp_q.push_back(16'h0321);
        show(4'b1110, 8'hF9, 8);
        settle();
        check("t6_value", {16'h0, bus.value}, 32'h0321);
        check("t6_fv", bus.frame_valid, 1);
        check("t6_chg_cnt", chg_cnt, 5);

        // timeout drops frame_valid but holds value; next frame pulses even if equal
        show(4'b1111, 8'hFF, Tmo + 20);
        check("t6_tmo_fv", bus.frame_valid, 0);
        check("t6_tmo_value", {16'h0, bus.value}, 32'h0321);
        exp_q.push_back(16'h0321);
        scan(8'hF9, 8'hA4, 8'hB0, 8'hC0, 8);
        settle();
        check("t6_refv", bus.frame_valid, 1);
        check("t6_rechg_cnt", chg_cnt, 6);
        check("final_err_cnt", err_cnt, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
